// File: rtl/sum_block_if.sv
// Handshake bundle between the adder stage, the block accumulator and its consumer.
interface sum_block_if #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 24
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_sum;
  logic             in_cout;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_ovf;

  modport master (output in_valid, in_sum, in_cout, out_ready,
                  input  in_ready, out_valid, out_data, out_ovf);
  modport slave  (input  in_valid, in_sum, in_cout, out_ready,
                  output in_ready, out_valid, out_data, out_ovf);
endinterface

// File: rtl/sum_block_accumulator.sv
// Sums BLOCK_LEN unsigned {cout,sum} samples into a saturating total and
// hands each finished block out over a one-deep valid/ready register.
module sum_block_accumulator #(
  parameter int IN_W      = 16,
  parameter int ACC_W     = 24,
  parameter int BLOCK_LEN = 8
) (
  input logic         clk,
  input logic         reset,
  input logic         clear,
  sum_block_if.slave  bus
);
  localparam int CNT_W = $clog2(BLOCK_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_LEN - 1);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt, out_data_q;
  logic [CNT_W-1:0] cnt;
  logic             ovf, out_ovf_q;
  logic [ACC_W:0]   sum_ext;
  logic             sat, last, accept, last_acc, take, load;

  // One spare bit catches the carry that signals saturation.
  assign sum_ext  = {1'b0, acc} + (ACC_W+1)'({bus.in_cout, bus.in_sum});
  assign sat      = sum_ext[ACC_W];
  assign acc_nxt  = sat ? '1 : sum_ext[ACC_W-1:0];

  assign last     = (cnt == LAST);
  assign take     = bus.out_valid & bus.out_ready;
  // Only the closing beat of a block has to wait for the output slot.
  assign bus.in_ready = !reset && !clear && !(last && bus.out_valid && !bus.out_ready);
  assign accept   = bus.in_valid & bus.in_ready;
  assign last_acc = accept & last;

  assign bus.out_valid = (state == FULL);
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      EMPTY: if (last_acc) begin
        state_nxt = FULL;
        load      = 1'b1;
      end
      FULL: begin
        if (last_acc) begin
          state_nxt = FULL;
          load      = 1'b1;
        end else if (take) begin
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= EMPTY;
      acc        <= '0;
      cnt        <= '0;
      ovf        <= 1'b0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        out_data_q <= acc_nxt;
        out_ovf_q  <= ovf | sat;
      end
      if (clear) begin
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end else if (accept) begin
        if (last) begin
          acc <= '0;
          cnt <= '0;
          ovf <= 1'b0;
        end else begin
          acc <= acc_nxt;
          cnt <= cnt + CNT_W'(1);
          ovf <= ovf | sat;
        end
      end
    end
  end
endmodule
